// File: rtl/cs_pkg.sv
// Shared definitions for the writable control store: FSM states, park word,
// sequencer field bit positions and a parity helper.
// Optional feature macro: CS_PARITY_EN (per-word even parity on the RAM).
package cs_pkg;

    localparam int CS_ADDR_W = 8;
    localparam int CS_DATA_W = 32;
    localparam int CS_DEPTH  = 256;

    // Microword driven while not running: bit2 clears the sequencer address.
    localparam logic [CS_DATA_W-1:0] CS_PARK_WORD = 32'h0000_0004;

    // Sequencer field bit positions within a microword.
    localparam int CS_BIT_INC      = 0;
    localparam int CS_BIT_DISPATCH = 1;
    localparam int CS_BIT_CLR      = 2;

    typedef enum logic [1:0] {
        CS_IDLE = 2'd0,
        CS_LOAD = 2'd1,
        CS_RUN  = 2'd2
    } cs_state_e;

    // Even-parity bit: makes the total count of ones (data + bit) even.
    function automatic logic even_parity(input logic [CS_DATA_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/control_store_if.sv
// Microcode loader handshake. A word moves on a clock edge where
// load_valid and load_ready are both high; load_start is a one-cycle pulse
// that (re)starts the load at address 0 and overrides load_valid.
interface control_store_if #(
    parameter int DATA_W = 32
) ();
    logic              load_start;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;

    modport master (
        output load_start, load_valid, load_data, load_last,
        input  load_ready
    );

    modport slave (
        input  load_start, load_valid, load_data, load_last,
        output load_ready
    );
endinterface

// File: rtl/cs_ram.sv
// Single-port synchronous microcode RAM with a registered read (the CBR).
// When park is high the read register loads PARK_WORD instead of memory.
// With CS_PARITY_EN each word carries an even-parity bit, checked on the
// registered read data.
module cs_ram
    import cs_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] PARK_WORD = CS_PARK_WORD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              park,
    output logic [DATA_W-1:0] rdata,
    output logic              perr
);

`ifdef CS_PARITY_EN
    localparam int MW = DATA_W + 1;
    logic [MW-1:0] wword;
    logic [MW-1:0] park_word;
    logic          rd_valid_q;
    assign wword     = {even_parity(wdata), wdata};
    assign park_word = {even_parity(PARK_WORD), PARK_WORD};
`else
    localparam int MW = DATA_W;
    logic [MW-1:0] wword;
    logic [MW-1:0] park_word;
    assign wword     = wdata;
    assign park_word = PARK_WORD;
`endif

    logic [MW-1:0] mem [0:(2**ADDR_W)-1];
    logic [MW-1:0] rd_q;

    // Memory write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wword;
    end

    // Control buffer register: parked word or memory read.
    always_ff @(posedge clk) begin
        if (rst || park) rd_q <= park_word;
        else             rd_q <= mem[addr];
    end

`ifdef CS_PARITY_EN
    // Marks rd_q as holding a real memory read, so only reads are checked.
    always_ff @(posedge clk) begin
        if (rst) rd_valid_q <= 1'b0;
        else     rd_valid_q <= !park;
    end
    assign perr = rd_valid_q && (^rd_q);
`else
    assign perr = 1'b0;
`endif

    assign rdata = rd_q[DATA_W-1:0];

endmodule

// File: rtl/control_store.sv
// Writable microprogram control store. Microcode is streamed in through the
// loader interface; while not running the CBR holds PARK_WORD so the
// sequencer sits at microaddress 0. In RUN the CBR follows ROM_address with
// one clock of latency.
// Optional feature macro: CS_PARITY_EN (parity error drops the store to IDLE).
module control_store
    import cs_pkg::*;
#(
    parameter int                ADDR_W    = CS_ADDR_W,
    parameter int                DATA_W    = CS_DATA_W,
    parameter int                DEPTH     = CS_DEPTH,
    parameter logic [DATA_W-1:0] PARK_WORD = CS_PARK_WORD
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    ROM_address,
    output logic [DATA_W-1:0]    control_signal,
    control_store_if.slave       ld,
    output logic                 running,
    output logic                 parity_err,
    output cs_state_e            state_dbg
);

    cs_state_e         state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              load_ready_q, load_ready_d;
    logic              running_q, running_d;
    logic              perr_q, perr_d;
    logic              we;
    logic              park;
    logic              ram_perr;
    logic [ADDR_W-1:0] ram_addr;

    // Next-state, load pointer and RAM control decode.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        load_ready_d = load_ready_q;
        running_d    = running_q;
        perr_d       = perr_q;
        we           = 1'b0;
        park         = 1'b1;
        case (state_q)
            CS_IDLE: begin
                if (ld.load_start) begin
                    state_d      = CS_LOAD;
                    ptr_d        = '0;
                    load_ready_d = 1'b1;
                end
            end
            CS_LOAD: begin
                if (ld.load_start) begin
                    ptr_d = '0;
                end else if (ld.load_valid) begin
                    we    = 1'b1;
                    ptr_d = ptr_q + 1'b1;
                    // Last slot forces the exit; the pointer never wraps in use.
                    if (ld.load_last || ptr_q == ADDR_W'(DEPTH - 1)) begin
                        state_d      = CS_RUN;
                        load_ready_d = 1'b0;
                        running_d    = 1'b1;
                    end
                end
            end
            CS_RUN: begin
                park = 1'b0;
                if (ld.load_start) begin
                    state_d      = CS_LOAD;
                    ptr_d        = '0;
                    load_ready_d = 1'b1;
                    running_d    = 1'b0;
                    park         = 1'b1;
                end else if (ram_perr) begin
                    state_d   = CS_IDLE;
                    running_d = 1'b0;
                    perr_d    = 1'b1;
                    park      = 1'b1;
                end
            end
            default: begin
                state_d      = CS_IDLE;
                load_ready_d = 1'b0;
                running_d    = 1'b0;
            end
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= CS_IDLE;
            ptr_q        <= '0;
            load_ready_q <= 1'b0;
            running_q    <= 1'b0;
            perr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            load_ready_q <= load_ready_d;
            running_q    <= running_d;
            perr_q       <= perr_d;
        end
    end

    // Single port: writes only happen in LOAD, reads only matter in RUN.
    assign ram_addr = we ? ptr_q : ROM_address;

    cs_ram #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .PARK_WORD (PARK_WORD)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .addr  (ram_addr),
        .wdata (ld.load_data),
        .park  (park),
        .rdata (control_signal),
        .perr  (ram_perr)
    );

    assign ld.load_ready = load_ready_q;
    assign running       = running_q;
    assign parity_err    = perr_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_control_store.sv
// Bench for control_store: a loader driver, an array model of the microcode
// memory and randomized RUN-state reads checked one clock after the address.
module tb_control_store;
    import cs_pkg::*;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam logic [DW-1:0] PARK = 32'h0000_0004;

    logic          clk;
    logic          rst;
    logic [AW-1:0] rom_address;
    logic [DW-1:0] control_signal;
    logic          running;
    logic          parity_err;
    cs_state_e     state_dbg;

    control_store_if #(.DATA_W(DW)) ld_if ();

    control_store dut (
        .clk            (clk),
        .rst            (rst),
        .ROM_address    (rom_address),
        .control_signal (control_signal),
        .ld             (ld_if),
        .running        (running),
        .parity_err     (parity_err),
        .state_dbg      (state_dbg)
    );

    // Reference model: what each address should hold after the last load.
    logic [DW-1:0] exp_mem [0:255];
    int n_cmp;
    int n_err;

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
    endtask

    // Stream n words starting at 0. gap_at: insert a 3-cycle valid-low hole
    // before that word (-1 for none). rnd_gaps adds random 0/1-cycle holes.
    task automatic load_burst(input int n, input bit use_last, input int gap_at,
                              input bit rnd_gaps, input bit fixed_a0);
        logic [DW-1:0] w;
        ld_if.load_start = 1'b1;
        step();
        ld_if.load_start = 1'b0;
        check("ready_in_load", {31'd0, ld_if.load_ready}, 32'd1);
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                ld_if.load_valid = 1'b0;
                ld_if.load_data  = $urandom;
                repeat (3) step();
            end else if (rnd_gaps && $urandom_range(0, 3) == 0) begin
                ld_if.load_valid = 1'b0;
                step();
            end
            w = fixed_a0 ? (32'hA0 + DW'(i)) : DW'($urandom);
            ld_if.load_valid = 1'b1;
            ld_if.load_data  = w;
            ld_if.load_last  = use_last && (i == n - 1);
            exp_mem[i] = w;
            step();
        end
        ld_if.load_valid = 1'b0;
        ld_if.load_last  = 1'b0;
        step();
        check("running_after_load", {31'd0, running}, 32'd1);
        check("ready_after_load", {31'd0, ld_if.load_ready}, 32'd0);
    endtask

    // Back-to-back reads: each address's word appears one clock later.
    task automatic rand_reads(input int count, input int max_addr);
        int a;
        for (int k = 0; k < count; k++) begin
            a = $urandom_range(0, max_addr);
            rom_address = AW'(a);
            step();
            check($sformatf("read[%0d]", a), control_signal, exp_mem[a]);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        rom_address = '0;
        ld_if.load_start = 1'b0;
        ld_if.load_valid = 1'b0;
        ld_if.load_data  = '0;
        ld_if.load_last  = 1'b0;
        for (int i = 0; i < 256; i++) exp_mem[i] = '0;

        // Reset and idle; a stray load_valid in IDLE is ignored.
        do_reset();
        ld_if.load_valid = 1'b1;
        ld_if.load_data  = 32'h1234_5678;
        repeat (5) step();
        ld_if.load_valid = 1'b0;
        check("idle_cbr", control_signal, PARK);
        check("idle_running", {31'd0, running}, 32'd0);
        check("idle_ready", {31'd0, ld_if.load_ready}, 32'd0);
        check("idle_perr", {31'd0, parity_err}, 32'd0);

        // Short burst A0..A3 terminated by load_last.
        load_burst(4, 1'b1, -1, 1'b0, 1'b1);
        rom_address = 8'd2;
        step();
        check("read_a2", control_signal, 32'h0000_00A2);
        rand_reads(8, 3);

        // Full 256-word burst with no load_last, a 3-cycle hole at word 100.
        load_burst(256, 1'b0, 100, 1'b1, 1'b0);
        rom_address = 8'd255;
        step();
        check("read_255", control_signal, exp_mem[255]);
        rom_address = 8'd100;
        step();
        check("read_after_gap", control_signal, exp_mem[100]);
        rom_address = 8'd99;
        step();
        check("read_before_gap", control_signal, exp_mem[99]);
        rand_reads(40, 255);

        // load_start with load_valid in RUN: restart wins, nothing written.
        rom_address = 8'd7;
        ld_if.load_start = 1'b1;
        ld_if.load_valid = 1'b1;
        ld_if.load_data  = 32'hDEAD_BEEF;
        step();
        ld_if.load_start = 1'b0;
        ld_if.load_valid = 1'b0;
        check("restart_state", {30'd0, state_dbg}, {30'd0, CS_LOAD});
        check("restart_cbr", control_signal, PARK);
        check("restart_running", {31'd0, running}, 32'd0);
        check("mem0_not_beef", dut.u_ram.mem[0][DW-1:0], exp_mem[0]);
        step();
        check("load_cbr_parked", control_signal, PARK);

        // Restart in the middle of a load: new burst begins again at 0.
        for (int i = 0; i < 3; i++) begin
            ld_if.load_valid = 1'b1;
            ld_if.load_data  = 32'hFFFF_0000 | DW'(i);
            step();
        end
        ld_if.load_valid = 1'b0;
        load_burst(10, 1'b1, -1, 1'b1, 1'b0);
        rand_reads(20, 9);

        // Reset in the middle of a load returns to IDLE and parks.
        ld_if.load_start = 1'b1;
        step();
        ld_if.load_start = 1'b0;
        ld_if.load_valid = 1'b1;
        ld_if.load_data  = $urandom;
        step();
        ld_if.load_valid = 1'b0;
        do_reset();
        check("rst_mid_state", {30'd0, state_dbg}, {30'd0, CS_IDLE});
        check("rst_mid_cbr", control_signal, PARK);
        check("rst_mid_ready", {31'd0, ld_if.load_ready}, 32'd0);

        // Reload after reset and read back.
        load_burst(16, 1'b1, -1, 1'b1, 1'b0);
        rand_reads(16, 15);

`ifdef CS_PARITY_EN
        // Corrupt the stored parity bit of address 5 and read it.
        dut.u_ram.mem[5][DW] = ~dut.u_ram.mem[5][DW];
        rom_address = 8'd5;
        step();
        check("perr_bad_word_out", control_signal, exp_mem[5]);
        rom_address = 8'd1;
        step();
        check("perr_flag", {31'd0, parity_err}, 32'd1);
        check("perr_running", {31'd0, running}, 32'd0);
        check("perr_cbr", control_signal, PARK);
        repeat (4) step();
        check("perr_sticky", {31'd0, parity_err}, 32'd1);
        do_reset();
        check("perr_cleared", {31'd0, parity_err}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/control_store.md
Name: control_store

Overview:
- Writable microprogram control memory with a registered control buffer register (CBR) at the output.
- Sits opposite the microprogram sequencer: it takes the sequencer's 8-bit microaddress and returns the 32-bit microword (control_signal) that drives the sequencer and datapath.
- Microcode is streamed in through a valid/ready loader after reset. While loading, the block parks the sequencer at microaddress 0.

Parameters:
- ADDR_W, 8, microaddress width.
- DATA_W, 32, microword width.
- DEPTH, 256, number of microwords; must equal 2**ADDR_W.
- PARK_WORD, 32'h0000_0004, microword driven while not running (bit2 = sequencer address clear).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ROM_address  in  ADDR_W  microaddress from sequencer.
- control_signal  out  DATA_W  registered microword (CBR).
- load_start  in  1  pulse: begin (re)load of control store from address 0.
- load_valid  in  1  load_data valid.
- load_data  in  DATA_W  microword to write.
- load_last  in  1  marks final word of load burst.
- load_ready  out  1  store accepts a word this cycle.
- running  out  1  high in RUN state.
- parity_err  out  1  sticky parity error flag; tied 0 without CS_PARITY_EN.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state IDLE, control_signal = PARK_WORD, load_ready = 0, running = 0, parity_err = 0, load pointer = 0. Memory contents are not reset.
- States:
  - IDLE: control_signal = PARK_WORD. load_start -> LOAD.
  - LOAD: load_ready = 1. Each cycle with load_valid & load_ready, write mem[ptr] = load_data and ptr++. If load_last is set, or ptr == DEPTH-1 on the write, go to RUN next cycle. control_signal stays PARK_WORD.
  - RUN: control_signal <= mem[ROM_address] every cycle; running = 1. load_start -> LOAD, ptr cleared, control_signal <= PARK_WORD next cycle.
- Latency: the microword for address A is visible on control_signal one clock after A is presented. The sequencer's microprogram is written for this one-stage CBR.
- The first RUN cycle outputs mem[ROM_address]. The sequencer was held at 0 by PARK_WORD, so execution starts at microword 0.
- Pointer wrap: ptr never wraps. A write at DEPTH-1 forces the exit to RUN whether or not load_last is set.
- load_start and load_valid in the same cycle: load_start wins. The word is not written and ptr := 0. In LOAD, load_start restarts the load at 0.
- load_valid while load_ready = 0 (IDLE/RUN): ignored, no write.
- load_last without load_valid: ignored.
- rst mid-load: returns to IDLE. Words already written stay in memory but are not trusted; a full reload is required.
- RUN-state read of an address never written: returns the memory contents as-is, with no X-masking requirement.

Optional Feature:
- Macro: CS_PARITY_EN.
- Defined:
  - Each word is stored with an even-parity bit (DATA_W+1 bits wide).
  - On every RUN read, parity is checked. On mismatch, parity_err is set (sticky until rst), the state goes to IDLE, and control_signal = PARK_WORD from the next cycle. The bad word is still output in the detecting cycle.
- Undefined: no parity bit; parity_err is constant 0.

Decomposition:
- Shared package cs_pkg holds:
  - state enum {CS_IDLE, CS_LOAD, CS_RUN};
  - CS_PARK_WORD constant;
  - bit positions of sequencer fields: CS_BIT_INC = 0, CS_BIT_DISPATCH = 1, CS_BIT_CLR = 2.
- One natural sub-module: cs_ram, a single-port synchronous RAM with a write port and a registered read, parity-extended when CS_PARITY_EN is defined.
- The FSM and the load pointer live in control_store.

Test Plan:
- Reset, then idle 5 cycles -> control_signal = 32'h0000_0004, running = 0, load_ready = 0.
- load_start, then stream 4 words 32'hA0..A3 with load_last on the 4th -> running = 1 two cycles after the last write. ROM_address = 2 gives 32'h0000_00A2 on the next clock.
- Stream 256 words with no load_last -> RUN entered after word 255. Read address 255 returns the last word.
- load_valid held low for 3 cycles mid-load -> ptr holds. The next valid word lands at the correct address (verify by readback).
- load_start + load_valid together in RUN with data 32'hDEAD_BEEF -> state LOAD, control_signal = 32'h0000_0004, and address 0 is not overwritten by DEADBEEF.
- CS_PARITY_EN: force a parity-bit flip at address 5, then read 5 -> parity_err = 1, running = 0, control_signal = 32'h0000_0004 on the following cycle. parity_err stays 1 until rst.
